// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, loader state encoding and error codes for the
//               8-bit computer boot path.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int OPCODE_W = 7;
    localparam int LIT_W    = 8;
    localparam int INSTR_W  = OPCODE_W + LIT_W;
    // Wide enough to hold a count of DEPTH itself (1..16 needs 5 bits).
    localparam int COUNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_WAIT_COUNT = 3'd0,
        S_WAIT_HI    = 3'd1,
        S_WAIT_LO    = 3'd2,
        S_WAIT_CSUM  = 3'd3,
        S_DONE       = 3'd4,
        S_ERROR      = 3'd5
    } loader_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_COUNT = 2'b01;
    localparam logic [1:0] ERR_BAD_HI    = 2'b10;
    localparam logic [1:0] ERR_CSUM      = 2'b11;

    // A frame must carry between 1 and DEPTH instructions.
    function automatic logic count_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor_checksum.sv
`default_nettype none
// ============================================================================
// Module      : xor_checksum
// Description : Running 8-bit XOR accumulator.
//               clk, rst_n : clock, asynchronous active-low reset
//               clear      : synchronous clear to zero (wins over en)
//               en         : fold din into the sum this cycle
//               din[7:0]   : byte to accumulate
//               sum[7:0]   : current accumulated XOR
// Revision    : 1.0 - initial release
// ============================================================================
module xor_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= 8'd0;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot loader. Receives COUNT, N x {HI, LO}, CSUM over a
//               valid/ready byte link, writes {opcode, literal} words into
//               instruction memory and releases the CPU after a good frame.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx_data/valid     : input byte stream; rx_ready accepts it
//   reload            : restart from DONE/ERROR
//   imem_we/addr/wdata: registered one-cycle instruction memory write
//   cpu_run           : high only after a good load
//   load_busy         : high while receiving
//   load_error        : high in ERROR, err_code gives the cause
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_run,
    output logic               load_busy,
    output logic               load_error,
    output logic [1:0]         err_code
);

    loader_state_t        r_state;
    logic [COUNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]    r_addr;
    logic [OPCODE_W-1:0]  r_opcode;

    logic                 w_xfer;
    logic                 w_receiving;
    logic                 w_finished;
    logic                 w_last;
    logic                 w_sum_en;
    logic                 w_sum_clr;
    logic [7:0]           w_sum;
    logic [COUNT_W-1:0]   w_addr_next;

    // rx_ready is a registered copy of "in a WAIT_* state", so it can be
    // used directly to qualify the transfer.
    assign w_xfer      = rx_valid & rx_ready;
    assign w_receiving = (r_state == S_WAIT_COUNT) || (r_state == S_WAIT_HI) ||
                         (r_state == S_WAIT_LO);
    assign w_finished  = (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_addr_next = {1'b0, r_addr} + COUNT_W'(1);
    assign w_last      = (w_addr_next == r_count);

    // COUNT, HI and LO bytes all fold into the checksum; the sum starts at
    // zero so folding COUNT leaves csum == N.
    assign w_sum_en    = w_xfer & w_receiving;
    assign w_sum_clr   = reload & w_finished;

    xor_checksum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_sum_clr),
        .en    (w_sum_en),
        .din   (rx_data),
        .sum   (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_COUNT;
            r_count    <= '0;
            r_addr     <= '0;
            r_opcode   <= '0;
            rx_ready   <= 1'b1;
            load_busy  <= 1'b1;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
            err_code   <= ERR_NONE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            // Write strobe is a single-cycle pulse.
            imem_we <= 1'b0;

            case (r_state)
                S_WAIT_COUNT: begin
                    if (w_xfer) begin
                        if (count_ok(rx_data)) begin
                            r_count <= rx_data[COUNT_W-1:0];
                            r_state <= S_WAIT_HI;
                        end else begin
                            r_state    <= S_ERROR;
                            rx_ready   <= 1'b0;
                            load_busy  <= 1'b0;
                            load_error <= 1'b1;
                            err_code   <= ERR_BAD_COUNT;
                        end
                    end
                end

                S_WAIT_HI: begin
                    if (w_xfer) begin
                        if (rx_data[7]) begin
                            r_state    <= S_ERROR;
                            rx_ready   <= 1'b0;
                            load_busy  <= 1'b0;
                            load_error <= 1'b1;
                            err_code   <= ERR_BAD_HI;
                        end else begin
                            r_opcode <= rx_data[OPCODE_W-1:0];
                            r_state  <= S_WAIT_LO;
                        end
                    end
                end

                S_WAIT_LO: begin
                    if (w_xfer) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_addr;
                        imem_wdata <= {r_opcode, rx_data};
                        // On the last entry of a 16-deep frame this rolls to
                        // zero, but the address is never used again.
                        r_addr     <= r_addr + 1'b1;
                        r_state    <= w_last ? S_WAIT_CSUM : S_WAIT_HI;
                    end
                end

                S_WAIT_CSUM: begin
                    if (w_xfer) begin
                        rx_ready  <= 1'b0;
                        load_busy <= 1'b0;
                        if (rx_data == w_sum) begin
                            r_state <= S_DONE;
                            cpu_run <= 1'b1;
                        end else begin
                            r_state    <= S_ERROR;
                            load_error <= 1'b1;
                            err_code   <= ERR_CSUM;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    if (reload) begin
                        r_state    <= S_WAIT_COUNT;
                        r_count    <= '0;
                        r_addr     <= '0;
                        rx_ready   <= 1'b1;
                        load_busy  <= 1'b1;
                        cpu_run    <= 1'b0;
                        load_error <= 1'b0;
                        err_code   <= ERR_NONE;
                    end
                end

                default: begin
                    r_state    <= S_WAIT_COUNT;
                    r_count    <= '0;
                    r_addr     <= '0;
                    rx_ready   <= 1'b1;
                    load_busy  <= 1'b1;
                    cpu_run    <= 1'b0;
                    load_error <= 1'b0;
                    err_code   <= ERR_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [14:0] imem_wdata;
    logic        cpu_run;
    logic        load_busy;
    logic        load_error;
    logic [1:0]  err_code;

    program_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_busy  (load_busy),
        .load_error (load_error),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Write log captured away from the active edge.
    logic [3:0]  wr_addr [256];
    logic [14:0] wr_data [256];
    int          wr_n = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    logic [7:0]  q [$];
    logic [14:0] exp_data [16];
    int          exp_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            rx_data = 8'($urandom);
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_queue(input int gapmax);
        foreach (q[i]) send_byte(q[i], $urandom_range(0, gapmax));
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_count"}, 32'(wr_n - base), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (base + i < wr_n) begin
                chk({tag, "_addr"}, {28'd0, wr_addr[base + i]}, 32'(i));
                chk({tag, "_data"}, {17'd0, wr_data[base + i]}, {17'd0, exp_data[i]});
            end
        end
    endtask

    task automatic frame1(input logic [7:0] csum);
        q.delete();
        q.push_back(8'h02);
        q.push_back(8'h05); q.push_back(8'h11);
        q.push_back(8'h0A); q.push_back(8'h22);
        q.push_back(csum);
        exp_n       = 2;
        exp_data[0] = 15'h0511;
        exp_data[1] = 15'h0A22;
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd1);
        chk({tag, "_load_busy"},  {31'd0, load_busy},  32'd1);
        chk({tag, "_cpu_run"},    {31'd0, cpu_run},    32'd0);
        chk({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
        chk({tag, "_err_code"},   {30'd0, err_code},   32'd0);
    endtask

    initial begin
        int base;
        logic [7:0] hi, lo, cs;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_idle("reset");
        chk("reset_imem_we", {31'd0, imem_we}, 32'd0);
        rst_n = 1'b1;

        // 1: good two-instruction frame.
        frame1(8'h3E);
        base = wr_n;
        for (int i = 0; i < 5; i++) send_byte(q[i], 0);
        chk("t1_cpu_run_before_csum", {31'd0, cpu_run}, 32'd0);
        send_byte(q[5], 0);
        chk("t1_cpu_run",   {31'd0, cpu_run},   32'd1);
        chk("t1_load_busy", {31'd0, load_busy}, 32'd0);
        chk("t1_rx_ready",  {31'd0, rx_ready},  32'd0);
        chk("t1_err_code",  {30'd0, err_code},  32'd0);
        check_writes("t1", base);

        // 2: full 16-entry frame with random idle gaps.
        do_reload();
        check_idle("t2_reload");
        q.delete();
        q.push_back(8'd16);
        cs = 8'd16;
        for (int i = 0; i < 16; i++) begin
            hi = 8'($urandom_range(0, 127));
            lo = 8'($urandom);
            q.push_back(hi);
            q.push_back(lo);
            cs = cs ^ hi ^ lo;
            exp_data[i] = {hi[6:0], lo};
        end
        q.push_back(cs);
        exp_n = 16;
        base  = wr_n;
        send_queue(3);
        chk("t2_cpu_run", {31'd0, cpu_run}, 32'd1);
        check_writes("t2", base);

        // 3: bad counts 0x00 and 0x11.
        do_reload();
        base = wr_n;
        send_byte(8'h00, 0);
        chk("t3a_load_error", {31'd0, load_error}, 32'd1);
        chk("t3a_err_code",   {30'd0, err_code},   32'd1);
        chk("t3a_rx_ready",   {31'd0, rx_ready},   32'd0);
        chk("t3a_load_busy",  {31'd0, load_busy},  32'd0);
        // Bytes offered in ERROR are ignored.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("t3a_err_hold", {30'd0, err_code}, 32'd1);
        do_reload();
        check_idle("t3_reload");
        send_byte(8'h11, 0);
        chk("t3b_load_error", {31'd0, load_error}, 32'd1);
        chk("t3b_err_code",   {30'd0, err_code},   32'd1);
        chk("t3_no_writes",   32'(wr_n - base),    32'd0);

        // 4: bad high byte, then reload and a good frame; reload pulsed
        //    mid-frame must be ignored.
        do_reload();
        base = wr_n;
        send_byte(8'h01, 0);
        send_byte(8'h85, 0);
        chk("t4_load_error", {31'd0, load_error}, 32'd1);
        chk("t4_err_code",   {30'd0, err_code},   32'd2);
        chk("t4_no_writes",  32'(wr_n - base),    32'd0);
        do_reload();
        chk("t4_err_cleared", {30'd0, err_code}, 32'd0);
        frame1(8'h3E);
        base = wr_n;
        send_byte(q[0], 0);
        do_reload();
        chk("t4_reload_ignored_busy", {31'd0, load_busy}, 32'd1);
        for (int i = 1; i < 6; i++) send_byte(q[i], 1);
        chk("t4_cpu_run",  {31'd0, cpu_run},  32'd1);
        chk("t4_err_code_done", {30'd0, err_code}, 32'd0);
        check_writes("t4", base);
        do_reload();
        chk("t4_cpu_run_falls", {31'd0, cpu_run}, 32'd0);

        // 5: checksum mismatch.
        frame1(8'h3F);
        base = wr_n;
        send_queue(0);
        chk("t5_err_code",   {30'd0, err_code},   32'd3);
        chk("t5_load_error", {31'd0, load_error}, 32'd1);
        chk("t5_cpu_run",    {31'd0, cpu_run},    32'd0);
        check_writes("t5", base);

        // 6: reset right after the first LO transfer cancels the pending write.
        do_reload();
        frame1(8'h3E);
        base = wr_n;
        send_byte(q[0], 0);
        send_byte(q[1], 0);
        send_byte(q[2], 0);
        rst_n = 1'b0;
        #1;
        chk("t6_we_cancelled", {31'd0, imem_we}, 32'd0);
        repeat (2) @(negedge clk);
        check_idle("t6_reset");
        chk("t6_no_writes", 32'(wr_n - base), 32'd0);
        rst_n = 1'b1;
        base = wr_n;
        send_queue(2);
        chk("t6_cpu_run", {31'd0, cpu_run}, 32'd1);
        check_writes("t6", base);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
